// File: rtl/notify_log.sv
// Violation logger: synchronizes notify flags, counts rising edges per channel and queues
// (channel, timestamp) records in a show-ahead FIFO. Define NOTIFY_LOG_DISPLAY_EN for event prints.
module notify_log #(
    parameter int NCH   = 4,
    parameter int CNT_W = 8,
    parameter int TS_W  = 16,
    parameter int DEPTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NCH-1:0]            notify,
    input  logic                      clr,
    input  logic                      rd_en,
    output logic                      rd_valid,
    output logic [2:0]                rd_chan,
    output logic [TS_W-1:0]           rd_ts,
    output logic [$clog2(DEPTH):0]    fifo_count,
    output logic                      overflow,
    output logic [NCH*CNT_W-1:0]      viol_cnt,
    output logic                      any_viol
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int RW = 3 + TS_W;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [NCH-1:0]   s1_p0, s2_p1, s3_p2, edge_p3;
    logic [NCH-1:0]   pending, cand, pick, pend_nxt;
    logic [2:0]       sel;
    logic             has_sel, full, pop, push_ok, drop;
    logic [TS_W-1:0]  ts;
    logic [CNT_W-1:0] cnt [NCH];
    logic [RW-1:0]    mem [DEPTH];
    logic [RW-1:0]    head;
    logic [AW-1:0]    wptr, rptr;
    logic [CW-1:0]    count;
    logic             ovf;

    // Lowest-index pending or newly detected channel is enqueued this cycle
    always_comb begin
        cand    = pending | edge_p3;
        has_sel = |cand;
        sel     = 3'd0;
        pick    = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (cand[i]) begin
                sel     = 3'(i);
                pick    = '0;
                pick[i] = 1'b1;
            end
        end
        pend_nxt = cand & ~pick;
    end

    assign full    = (count == CW'(DEPTH));
    assign pop     = rd_en && (count != '0);
    assign push_ok = has_sel && (!full || pop);
    assign drop    = has_sel && full && !pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_p0   <= '0;
            s2_p1   <= '0;
            s3_p2   <= '0;
            edge_p3 <= '0;
            pending <= '0;
            ts      <= '0;
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            ovf     <= 1'b0;
            for (int i = 0; i < NCH; i++) cnt[i] <= '0;
        end else begin
            s1_p0   <= notify;
            s2_p1   <= s1_p0;
            s3_p2   <= s2_p1;
            // Registered edge detect: one cycle between edge and enqueue
            edge_p3 <= s2_p1 & ~s3_p2;
            if (clr) begin
                pending <= '0;
                ts      <= '0;
                wptr    <= '0;
                rptr    <= '0;
                count   <= '0;
                ovf     <= 1'b0;
                for (int i = 0; i < NCH; i++) cnt[i] <= '0;
            end else begin
                ts      <= ts + TS_W'(1);
                pending <= pend_nxt;
                for (int i = 0; i < NCH; i++) begin
                    if (edge_p3[i]) cnt[i] <= sat_inc(cnt[i]);
                end
                if (push_ok) wptr <= wptr + AW'(1);
                if (pop)     rptr <= rptr + AW'(1);
                case ({push_ok, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
                if (drop) ovf <= 1'b1;
            end
        end
    end

    // Record storage carries no reset; outputs are masked while empty
    always_ff @(posedge clk) begin
        if (!reset && !clr && push_ok) mem[wptr] <= {sel, ts};
    end

    assign head       = mem[rptr];
    assign rd_valid   = (count != '0);
    assign rd_chan    = rd_valid ? head[RW-1 -: 3] : 3'd0;
    assign rd_ts      = rd_valid ? head[TS_W-1:0] : '0;
    assign fifo_count = count;
    assign overflow   = ovf;
    assign any_viol   = |s2_p1;

    for (genvar g = 0; g < NCH; g++) begin : g_cnt
        assign viol_cnt[g*CNT_W +: CNT_W] = cnt[g];
    end

`ifdef NOTIFY_LOG_DISPLAY_EN
    always @(posedge clk) begin
        if (!reset && !clr) begin
            if (push_ok) $display("ch %0d ts %0d", sel, ts);
            if (drop)    $display("drop ch %0d", sel);
            for (int i = 0; i < NCH; i++) begin
                if (edge_p3[i] && cnt[i] == {{(CNT_W-1){1'b1}}, 1'b0})
                    $display("ch %0d counter saturated", i);
            end
        end
    end
`endif

endmodule

// File: tb/tb_notify_log.sv
// Directed bench for notify_log: per-cycle vector table plus hand-written multi-cycle sequences.
module tb_notify_log;

    localparam int NCH = 4, CNT_W = 8, TS_W = 16, DEPTH = 8;

    logic                   clk = 1'b0;
    logic                   reset, clr, rd_en;
    logic [NCH-1:0]         notify;
    logic                   rd_valid;
    logic [2:0]             rd_chan;
    logic [TS_W-1:0]        rd_ts;
    logic [3:0]             fifo_count;
    logic                   overflow;
    logic [NCH*CNT_W-1:0]   viol_cnt;
    logic                   any_viol;

    int checks = 0;
    int failures = 0;

    notify_log #(.NCH(NCH), .CNT_W(CNT_W), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .notify(notify), .clr(clr), .rd_en(rd_en),
        .rd_valid(rd_valid), .rd_chan(rd_chan), .rd_ts(rd_ts), .fifo_count(fifo_count),
        .overflow(overflow), .viol_cnt(viol_cnt), .any_viol(any_viol)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  nt;
        logic        c;
        logic        rd;
        logic        v;
        logic [2:0]  ch;
        logic [15:0] ts;
        logic [3:0]  cnt;
        logic        ov;
        logic        any;
        logic [31:0] vc;
    } vec_t;

    vec_t tbl [17];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int ch, input int n);
        for (int k = 0; k < n; k++) begin
            notify[ch] = 1'b1;
            step(2);
            notify[ch] = 1'b0;
            step(2);
        end
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step(1);
        clr = 1'b0;
    endtask

    initial begin
        logic [TS_W-1:0] prev_ts;

        //          nt       c  rd  v  ch  ts   cnt ov any vc
        tbl[0]  = '{4'b0000, 1, 0,  0, 0,  0,   0,  0, 0,  32'h0};
        tbl[1]  = '{4'b0010, 0, 0,  0, 0,  0,   0,  0, 0,  32'h0};
        tbl[2]  = '{4'b0010, 0, 0,  0, 0,  0,   0,  0, 1,  32'h0};
        tbl[3]  = '{4'b0010, 0, 0,  0, 0,  0,   0,  0, 1,  32'h0};
        tbl[4]  = '{4'b0000, 0, 0,  1, 1,  3,   1,  0, 1,  32'h00000100};
        tbl[5]  = '{4'b0000, 0, 0,  1, 1,  3,   1,  0, 0,  32'h00000100};
        tbl[6]  = '{4'b0000, 0, 1,  0, 0,  0,   0,  0, 0,  32'h00000100};
        tbl[7]  = '{4'b1101, 0, 0,  0, 0,  0,   0,  0, 0,  32'h00000100};
        tbl[8]  = '{4'b1101, 0, 0,  0, 0,  0,   0,  0, 1,  32'h00000100};
        tbl[9]  = '{4'b1101, 0, 0,  0, 0,  0,   0,  0, 1,  32'h00000100};
        tbl[10] = '{4'b1101, 0, 0,  1, 0,  9,   1,  0, 1,  32'h01010101};
        tbl[11] = '{4'b1101, 0, 0,  1, 0,  9,   2,  0, 1,  32'h01010101};
        tbl[12] = '{4'b1101, 0, 0,  1, 0,  9,   3,  0, 1,  32'h01010101};
        tbl[13] = '{4'b0000, 0, 1,  1, 2,  10,  2,  0, 1,  32'h01010101};
        tbl[14] = '{4'b0000, 0, 1,  1, 3,  11,  1,  0, 0,  32'h01010101};
        tbl[15] = '{4'b0000, 0, 1,  0, 0,  0,   0,  0, 0,  32'h01010101};
        tbl[16] = '{4'b0000, 0, 1,  0, 0,  0,   0,  0, 0,  32'h01010101};

        reset = 1'b1; clr = 1'b0; rd_en = 1'b0; notify = '0;
        step(2);
        check("reset rd_valid", rd_valid, 0);
        check("reset fifo_count", fifo_count, 0);
        check("reset overflow", overflow, 0);
        check("reset viol_cnt", viol_cnt, 0);
        check("reset any_viol", any_viol, 0);
        check("reset rd_chan", rd_chan, 0);
        check("reset rd_ts", rd_ts, 0);
        reset = 1'b0;

        // Single event on ch1, then simultaneous events on ch0/2/3
        for (int i = 0; i < 17; i++) begin
            notify = tbl[i].nt;
            clr    = tbl[i].c;
            rd_en  = tbl[i].rd;
            step(1);
            check($sformatf("row%0d rd_valid", i), rd_valid, tbl[i].v);
            check($sformatf("row%0d rd_chan", i), rd_chan, tbl[i].ch);
            check($sformatf("row%0d rd_ts", i), rd_ts, tbl[i].ts);
            check($sformatf("row%0d fifo_count", i), fifo_count, tbl[i].cnt);
            check($sformatf("row%0d overflow", i), overflow, tbl[i].ov);
            check($sformatf("row%0d any_viol", i), any_viol, tbl[i].any);
            check($sformatf("row%0d viol_cnt", i), viol_cnt, tbl[i].vc);
        end
        notify = '0; clr = 1'b0; rd_en = 1'b0;

        // Overflow: 10 records into an 8-deep FIFO
        do_clr();
        pulse(0, 10);
        step(6);
        check("ovf fifo_count", fifo_count, 8);
        check("ovf overflow", overflow, 1);
        check("ovf viol_cnt0", viol_cnt[7:0], 10);
        check("ovf first chan", rd_chan, 0);
        check("ovf first ts", rd_ts, 3);
        rd_en = 1'b1;
        prev_ts = '0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) check($sformatf("ovf ts step %0d", k), rd_ts - prev_ts, 4);
            prev_ts = rd_ts;
            step(1);
        end
        rd_en = 1'b0;
        check("ovf drained rd_valid", rd_valid, 0);
        check("ovf sticky", overflow, 1);

        // Full FIFO with push and pop in the same cycle
        do_clr();
        pulse(0, 8);
        step(6);
        check("full fifo_count", fifo_count, 8);
        notify[0] = 1'b1;
        step(3);
        rd_en = 1'b1;
        step(1);
        rd_en = 1'b0;
        notify[0] = 1'b0;
        check("full pushpop count", fifo_count, 8);
        check("full pushpop overflow", overflow, 0);
        check("full pushpop head ts", rd_ts, 7);

        // Counter saturation
        do_clr();
        pulse(2, 300);
        step(6);
        check("sat viol_cnt2", viol_cnt[23:16], 255);
        check("sat viol_cnt0", viol_cnt[7:0], 0);

        // Asynchronous reset between edges with records queued
        do_clr();
        pulse(1, 5);
        step(6);
        check("rst pre count", fifo_count, 5);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("rst async rd_valid", rd_valid, 0);
        check("rst async fifo_count", fifo_count, 0);
        check("rst async viol_cnt", viol_cnt, 0);
        check("rst async rd_chan", rd_chan, 0);
        notify[3] = 1'b1;
        @(posedge clk);
        #3 reset = 1'b0;
        step(10);
        check("rst post count", fifo_count, 1);
        check("rst post chan", rd_chan, 3);
        check("rst post viol_cnt", viol_cnt, 32'h01000000);
        check("rst post any_viol", any_viol, 1);
        rd_en = 1'b1;
        step(1);
        rd_en = 1'b0;
        check("rst post drained", rd_valid, 0);
        notify = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/notify_log.md
Name: notify_log

Overview:
- Synchronous logger downstream of the setup-check instrumentation.
- Consumes the asynchronous `notify` violation flags from up to NCH checker instances and counts rising edges per channel.
- Queues each violation as a (channel, timestamp) record in a small show-ahead FIFO.
- A testbench or readout block drains the FIFO through a valid/read handshake.

Parameters:
- NCH, 4, number of notify channels (1..8).
- CNT_W, 8, width of each per-channel violation counter.
- TS_W, 16, width of the free-running timestamp counter.
- DEPTH, 8, FIFO depth in records (power of two, >= 2).

Ports:
- clk  input  1  Clock; all state updates on rising edge.
- reset  input  1  Asynchronous active-high reset.
- notify  input  NCH  Asynchronous violation flags, one per checker.
- clr  input  1  Synchronous clear of counters, FIFO, pending bits and overflow.
- rd_en  input  1  Pop request; effective only when rd_valid=1.
- rd_valid  output  1  FIFO non-empty; head record is present on rd_chan/rd_ts.
- rd_chan  output  3  Channel index of the head record.
- rd_ts  output  TS_W  Timestamp of the head record.
- fifo_count  output  clog2(DEPTH)+1  Number of records currently stored.
- overflow  output  1  Sticky: a record was dropped because the FIFO was full.
- viol_cnt  output  NCH*CNT_W  Per-channel counters; channel i occupies bits [i*CNT_W +: CNT_W].
- any_viol  output  1  OR of all synchronized notify bits.

Behaviour:
- **Reset state:** reset=1 clears all registers immediately, regardless of clk. Outputs are then rd_valid=0, rd_chan=0, rd_ts=0, fifo_count=0, overflow=0, viol_cnt=0, any_viol=0, and the timestamp counter is 0.
- **Synchronizer:** two flops per channel (s1, s2), plus a third flop (s3) for edge detection. A channel edge is `s2 & ~s3`.
- **Timestamp counter:** free-running, +1 every cycle, wraps from 2^TS_W-1 to 0. Held at 0 while clr=1.
- **Counters:** viol_cnt[i] increments on every detected edge of channel i. It saturates at 2^CNT_W-1 and never wraps. Counting is independent of FIFO state.
- **Pending register:** NCH bits. Detected edges are OR-ed into pending. An edge on a channel whose pending bit is already set merges into it: one record is queued, but the count is still incremented.
- **Enqueue:** at most one record per cycle, taken from the lowest-index bit of (pending | current edges).
  - That bit is cleared.
  - The stored record is {index, timestamp value in the enqueue cycle}.
  - Deferred records therefore carry later timestamps.
- **Latency:** notify rising and meeting the sampling edge n gives an edge detected in cycle n+2. The record is written at edge n+3, so rd_valid=1 after edge n+3 when the FIFO was empty and no other channel was pending.
- **FIFO:** show-ahead; the head is always driven while rd_valid=1. Pop occurs at a clock edge with rd_en & rd_valid. rd_en while empty is ignored.
- **Full FIFO:**
  - An enqueue while full, with no pop in the same cycle, drops the record.
  - The pending bit is still cleared and overflow is set.
  - Push and pop in the same cycle while full both succeed and fifo_count is unchanged.
  - Push and pop in the same cycle while empty: the new record is written and the pop is ignored.
- **Pointers:** wrap modulo DEPTH; full/empty are distinguished by fifo_count.
- **overflow:** cleared only by reset or clr.
- **clr:** one-cycle synchronous clear of counters, FIFO, pending, overflow and timestamp. Synchronizer flops are not cleared. clr takes priority over a simultaneous edge, enqueue or pop.
- **Reset mid-operation:** all records and pending events are lost. Synchronizer flops return to 0, so a notify still high after reset produces one fresh edge.

Optional Feature:
- Macro: NOTIFY_LOG_DISPLAY_EN.
- Defined: simulation-only $display on each enqueue ("ch %0d ts %0d"), on each drop ("drop ch %0d"), and on each counter reaching saturation.
- Undefined: no display statements are compiled; logic is identical.

Test Plan:
- Single event: reset, then a notify[1] pulse of 3 cycles → rd_valid=1 three edges after the first sampling edge; rd_chan=1; viol_cnt[1]=1; pop → rd_valid=0, fifo_count=0.
- Simultaneous events: notify[0], [2] and [3] rise on the same cycle → three records in order ch 0, 2, 3, with consecutive timestamps T, T+1, T+2; each count=1.
- Overflow: 10 separated pulses on notify[0] with no reads and DEPTH=8 → fifo_count=8, overflow=1, viol_cnt[0]=10; 8 pops return increasing timestamps.
- Full with simultaneous pop: FIFO full, rd_en=1 held while a new edge is enqueued → fifo_count stays 8, overflow stays 0.
- Saturation: 300 pulses on notify[2] with CNT_W=8 → viol_cnt[2]=255.
- Async reset mid-run: reset asserted between clock edges with 5 records queued → outputs 0 immediately; after release, notify[3] held high → exactly one record for ch 3.
